// File: rtl/load_use_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : load_use_scoreboard
// Purpose  : ID-stage load-use interlock with an aging in-flight load
//            scoreboard and a saturating stall-cycle counter.
// Revision : 1.0
// ============================================================================
module load_use_scoreboard #(
    parameter int REG_ADDR_W    = 5,
    parameter int NUM_SRC       = 2,
    parameter int LOAD_LAT      = 1,
    parameter int ZERO_REG_SKIP = 1,
    parameter int CNT_W         = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          MemStall,
    input  logic                          flush,
    input  logic                          id_valid,
    input  logic                          id_mem_read,
    input  logic [REG_ADDR_W-1:0]         id_rd,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] id_rs,
    input  logic [NUM_SRC-1:0]            id_rs_used,
    output logic                          hazard_stall,
    output logic [NUM_SRC-1:0]            hazard_src,
    output logic [CNT_W-1:0]              stall_cnt
);

    logic [LOAD_LAT-1:0]   slot_vld_q;
    logic [LOAD_LAT-1:0]   slot_vld_d;
    logic [REG_ADDR_W-1:0] slot_rd_q [LOAD_LAT];
    logic [REG_ADDR_W-1:0] slot_rd_d [LOAD_LAT];
    logic [CNT_W-1:0]      stall_cnt_q;
    logic [CNT_W-1:0]      stall_cnt_d;
    logic                  w_issue_load;

    // Slot 0 is the youngest in-flight load; a match in any slot blocks issue.
    always_comb begin
        hazard_src = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            for (int i = 0; i < LOAD_LAT; i++) begin
                if (id_rs_used[k] && slot_vld_q[i] &&
                    (slot_rd_q[i] == id_rs[k*REG_ADDR_W +: REG_ADDR_W]) &&
                    ((ZERO_REG_SKIP == 0) ||
                     (id_rs[k*REG_ADDR_W +: REG_ADDR_W] != '0))) begin
                    hazard_src[k] = 1'b1;
                end
            end
        end
        if (!id_valid || flush) begin
            hazard_src = '0;
        end
    end

    assign hazard_stall = |hazard_src;

    assign w_issue_load = id_valid && id_mem_read && !flush && !hazard_stall &&
                          ((ZERO_REG_SKIP == 0) || (id_rd != '0));

    always_comb begin
        slot_vld_d = slot_vld_q;
        slot_rd_d  = slot_rd_q;
        if (!MemStall) begin
            for (int i = LOAD_LAT - 1; i > 0; i--) begin
                slot_vld_d[i] = slot_vld_q[i-1];
                slot_rd_d[i]  = slot_rd_q[i-1];
            end
            slot_vld_d[0] = w_issue_load;
            slot_rd_d[0]  = id_rd;
        end
    end

    // Frozen cycles are not counted; the counter sticks at all-ones.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (hazard_stall && !MemStall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_vld_q  <= '0;
            stall_cnt_q <= '0;
            for (int i = 0; i < LOAD_LAT; i++) begin
                slot_rd_q[i] <= '0;
            end
        end else begin
            slot_vld_q  <= slot_vld_d;
            slot_rd_q   <= slot_rd_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_load_use_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_load_use_scoreboard
// Purpose  : Self-checking bench; two instances (LOAD_LAT=1/CNT_W=4 and
//            LOAD_LAT=3/CNT_W=32) share one instruction stream.
// Revision : 1.0
// ============================================================================
module tb_load_use_scoreboard;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        MemStall = 1'b0;
    logic        flush = 1'b0;
    logic        id_valid = 1'b0;
    logic        id_mem_read = 1'b0;
    logic [4:0]  id_rd = '0;
    logic [9:0]  id_rs = '0;
    logic [1:0]  id_rs_used = '0;
    logic        a_stall, b_stall;
    logic [1:0]  a_src, b_src;
    logic [3:0]  a_cnt;
    logic [31:0] b_cnt;

    load_use_scoreboard #(.REG_ADDR_W(5), .NUM_SRC(2), .LOAD_LAT(1),
                          .ZERO_REG_SKIP(1), .CNT_W(4)) dut_a (
        .clk(clk), .rst(rst), .MemStall(MemStall), .flush(flush),
        .id_valid(id_valid), .id_mem_read(id_mem_read), .id_rd(id_rd),
        .id_rs(id_rs), .id_rs_used(id_rs_used),
        .hazard_stall(a_stall), .hazard_src(a_src), .stall_cnt(a_cnt));

    load_use_scoreboard #(.REG_ADDR_W(5), .NUM_SRC(2), .LOAD_LAT(3),
                          .ZERO_REG_SKIP(1), .CNT_W(32)) dut_b (
        .clk(clk), .rst(rst), .MemStall(MemStall), .flush(flush),
        .id_valid(id_valid), .id_mem_read(id_mem_read), .id_rd(id_rd),
        .id_rs(id_rs), .id_rs_used(id_rs_used),
        .hazard_stall(b_stall), .hazard_src(b_src), .stall_cnt(b_cnt));

    always #5 clk = ~clk;

    typedef struct {
        bit       ms;
        bit       fl;
        bit       v;
        bit       mr;
        bit [4:0] rd;
        bit [4:0] rs0;
        bit [4:0] rs1;
        bit [1:0] used;
        bit       sa;
        bit [1:0] srca;
        bit       sb;
        bit [1:0] srcb;
    } vec_t;

    typedef struct {
        logic [4:0] rd;
        int         t;
    } ent_t;

    typedef struct {
        logic        sa;
        logic [1:0]  srca;
        logic [3:0]  cnta;
        logic        sb;
        logic [1:0]  srcb;
        logic [31:0] cntb;
    } exp_t;

    vec_t        tab[$];
    ent_t        qa[$];
    ent_t        qb[$];
    exp_t        sbq[$];
    int          tick = 0;
    logic [3:0]  m_cnta = '0;
    logic [31:0] m_cntb = '0;
    int          n_chk = 0;
    int          n_fail = 0;

    function automatic vec_t mk(bit ms, bit fl, bit v, bit mr, bit [4:0] rd,
                                bit [4:0] rs0, bit [4:0] rs1, bit [1:0] used,
                                bit sa, bit [1:0] srca, bit sb, bit [1:0] srcb);
        vec_t r;
        r.ms = ms; r.fl = fl; r.v = v; r.mr = mr; r.rd = rd;
        r.rs0 = rs0; r.rs1 = rs1; r.used = used;
        r.sa = sa; r.srca = srca; r.sb = sb; r.srcb = srcb;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // A load is in flight for LOAD_LAT unfrozen edges after the edge it issued on.
    function automatic logic [1:0] ref_src(input int which, input int lat);
        logic [1:0] m;
        logic [4:0] rs;
        m = '0;
        for (int k = 0; k < 2; k++) begin
            rs = (k == 0) ? id_rs[4:0] : id_rs[9:5];
            if (id_rs_used[k] && rs != 5'd0) begin
                if (which == 0) begin
                    foreach (qa[i]) if ((tick - qa[i].t) <= lat && qa[i].rd == rs) m[k] = 1'b1;
                end else begin
                    foreach (qb[i]) if ((tick - qb[i].t) <= lat && qb[i].rd == rs) m[k] = 1'b1;
                end
            end
        end
        if (!id_valid || flush) m = '0;
        return m;
    endfunction

    task automatic drive(input vec_t v);
        MemStall    = v.ms;
        flush       = v.fl;
        id_valid    = v.v;
        id_mem_read = v.mr;
        id_rd       = v.rd;
        id_rs       = {v.rs1, v.rs0};
        id_rs_used  = v.used;
    endtask

    task automatic eval_cycle();
        exp_t e;
        exp_t g;
        logic [1:0] ma, mb;
        #1;
        ma = ref_src(0, 1);
        mb = ref_src(1, 3);
        e.sa = |ma; e.srca = ma; e.cnta = m_cnta;
        e.sb = |mb; e.srcb = mb; e.cntb = m_cntb;
        sbq.push_back(e);
        g = sbq.pop_front();
        chk("sb a_stall", a_stall, g.sa);
        chk("sb a_src",   a_src,   g.srca);
        chk("sb a_cnt",   a_cnt,   g.cnta);
        chk("sb b_stall", b_stall, g.sb);
        chk("sb b_src",   b_src,   g.srcb);
        chk("sb b_cnt",   b_cnt,   g.cntb);
        if (!MemStall) begin
            if (id_valid && id_mem_read && !flush && id_rd != 5'd0) begin
                if (!e.sa) qa.push_back('{id_rd, tick});
                if (!e.sb) qb.push_back('{id_rd, tick});
            end
            if (e.sa && m_cnta != 4'hF) m_cnta = m_cnta + 4'd1;
            if (e.sb && m_cntb != 32'hFFFF_FFFF) m_cntb = m_cntb + 32'd1;
            tick++;
        end
    endtask

    task automatic apply(input vec_t v, input bit tab_chk, input int idx);
        @(negedge clk);
        drive(v);
        eval_cycle();
        if (tab_chk) begin
            chk($sformatf("row%0d a_stall", idx), a_stall, v.sa);
            chk($sformatf("row%0d a_src", idx),   a_src,   v.srca);
            chk($sformatf("row%0d b_stall", idx), b_stall, v.sb);
            chk($sformatf("row%0d b_src", idx),   b_src,   v.srcb);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t nop;
        vec_t ld5;
        nop = mk(0,0,0,0,5'd0,5'd0,5'd0,2'b00, 0,2'b00,0,2'b00);
        ld5 = mk(0,0,1,1,5'd5,5'd1,5'd0,2'b01, 0,2'b00,0,2'b00);

        // back-to-back dependency; B (LAT=3) stalls 3 cycles
        tab.push_back(ld5);
        tab.push_back(mk(0,0,1,0,5'd0,5'd5,5'd6,2'b11, 1,2'b01,1,2'b01));
        tab.push_back(mk(0,0,1,0,5'd0,5'd5,5'd6,2'b11, 0,2'b00,1,2'b01));
        tab.push_back(mk(0,0,1,0,5'd0,5'd5,5'd6,2'b11, 0,2'b00,1,2'b01));
        tab.push_back(mk(0,0,1,0,5'd0,5'd5,5'd6,2'b11, 0,2'b00,0,2'b00));
        // distance-2 consumer on rs1
        tab.push_back(mk(0,0,1,1,5'd7,5'd1,5'd0,2'b01, 0,2'b00,0,2'b00));
        tab.push_back(mk(0,0,1,0,5'd0,5'd3,5'd4,2'b11, 0,2'b00,0,2'b00));
        tab.push_back(mk(0,0,1,0,5'd0,5'd2,5'd7,2'b11, 0,2'b00,1,2'b10));
        tab.push_back(mk(0,0,1,0,5'd0,5'd2,5'd7,2'b11, 0,2'b00,1,2'b10));
        tab.push_back(mk(0,0,1,0,5'd0,5'd2,5'd7,2'b11, 0,2'b00,0,2'b00));
        // MemStall freezes the stall for 3 cycles
        tab.push_back(ld5);
        tab.push_back(mk(1,0,1,0,5'd0,5'd5,5'd0,2'b01, 1,2'b01,1,2'b01));
        tab.push_back(mk(1,0,1,0,5'd0,5'd5,5'd0,2'b01, 1,2'b01,1,2'b01));
        tab.push_back(mk(1,0,1,0,5'd0,5'd5,5'd0,2'b01, 1,2'b01,1,2'b01));
        tab.push_back(mk(0,0,1,0,5'd0,5'd5,5'd0,2'b01, 1,2'b01,1,2'b01));
        tab.push_back(mk(0,0,1,0,5'd0,5'd5,5'd0,2'b01, 0,2'b00,1,2'b01));
        tab.push_back(mk(0,0,1,0,5'd0,5'd5,5'd0,2'b01, 0,2'b00,1,2'b01));
        tab.push_back(mk(0,0,1,0,5'd0,5'd5,5'd0,2'b01, 0,2'b00,0,2'b00));
        // flush: flushed load x12 reading x9 neither stalls nor is recorded
        tab.push_back(mk(0,0,1,1,5'd9,5'd1,5'd0,2'b01, 0,2'b00,0,2'b00));
        tab.push_back(mk(0,1,1,1,5'd12,5'd9,5'd0,2'b01, 0,2'b00,0,2'b00));
        tab.push_back(mk(0,0,1,0,5'd0,5'd12,5'd12,2'b11, 0,2'b00,0,2'b00));
        // zero register
        tab.push_back(mk(0,0,1,1,5'd0,5'd1,5'd0,2'b01, 0,2'b00,0,2'b00));
        tab.push_back(mk(0,0,1,0,5'd0,5'd0,5'd0,2'b11, 0,2'b00,0,2'b00));
        // id_rs_used gating
        tab.push_back(mk(0,0,1,1,5'd9,5'd1,5'd0,2'b01, 0,2'b00,0,2'b00));
        tab.push_back(mk(0,0,1,0,5'd0,5'd9,5'd9,2'b00, 0,2'b00,0,2'b00));
        tab.push_back(mk(0,0,1,0,5'd0,5'd9,5'd9,2'b10, 0,2'b00,1,2'b10));
        tab.push_back(mk(0,0,1,0,5'd0,5'd9,5'd9,2'b10, 0,2'b00,1,2'b10));
        tab.push_back(mk(0,0,1,0,5'd0,5'd9,5'd9,2'b10, 0,2'b00,0,2'b00));
        // self-dependent load, then an invalid slot that would otherwise match
        tab.push_back(mk(0,0,1,1,5'd11,5'd11,5'd0,2'b01, 0,2'b00,0,2'b00));
        tab.push_back(mk(0,0,0,0,5'd0,5'd11,5'd11,2'b11, 0,2'b00,0,2'b00));
        // matches in two slots and two sources give one stall
        tab.push_back(mk(0,0,1,1,5'd13,5'd1,5'd0,2'b01, 0,2'b00,0,2'b00));
        tab.push_back(mk(0,0,1,0,5'd0,5'd13,5'd11,2'b11, 1,2'b01,1,2'b11));
        tab.push_back(mk(0,0,1,0,5'd0,5'd13,5'd11,2'b11, 0,2'b00,1,2'b01));
        tab.push_back(mk(0,0,1,0,5'd0,5'd13,5'd11,2'b11, 0,2'b00,1,2'b01));
        tab.push_back(mk(0,0,1,0,5'd0,5'd13,5'd11,2'b11, 0,2'b00,0,2'b00));

        #1 rst = 1'b1;
        #2;
        chk("reset a_stall", a_stall, 1'b0);
        chk("reset a_src",   a_src,   2'b00);
        chk("reset a_cnt",   a_cnt,   4'h0);
        chk("reset b_stall", b_stall, 1'b0);
        chk("reset b_cnt",   b_cnt,   32'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < tab.size(); i++) begin
            apply(tab[i], 1'b1, i);
        end
        apply(nop, 1'b0, 0);
        chk("table a_cnt", a_cnt, 4'd3);
        chk("table b_cnt", b_cnt, 32'd13);

        // asynchronous reset between a load and its consumer
        apply(ld5, 1'b0, 0);
        @(negedge clk);
        drive(mk(0,0,1,0,5'd0,5'd5,5'd0,2'b01, 0,2'b00,0,2'b00));
        #1;
        chk("prerst a_stall", a_stall, 1'b1);
        chk("prerst b_stall", b_stall, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("async rst a_stall", a_stall, 1'b0);
        chk("async rst a_src",   a_src,   2'b00);
        chk("async rst a_cnt",   a_cnt,   4'h0);
        chk("async rst b_stall", b_stall, 1'b0);
        chk("async rst b_src",   b_src,   2'b00);
        chk("async rst b_cnt",   b_cnt,   32'h0);
        qa.delete();
        qb.delete();
        m_cnta = '0;
        m_cntb = '0;
        @(negedge clk);
        rst = 1'b0;
        eval_cycle();
        chk("postrst a_stall", a_stall, 1'b0);
        chk("postrst b_stall", b_stall, 1'b0);

        // self-dependent load x5 repeated: A alternates issue/stall, 20 stalls
        for (int i = 0; i < 40; i++) begin
            apply(mk(0,0,1,1,5'd5,5'd5,5'd0,2'b01, 0,2'b00,0,2'b00), 1'b0, 0);
        end
        apply(nop, 1'b0, 0);
        chk("sat a_cnt", a_cnt, 4'hF);
        for (int i = 0; i < 6; i++) begin
            apply(mk(0,0,1,1,5'd5,5'd5,5'd0,2'b01, 0,2'b00,0,2'b00), 1'b0, 0);
        end
        apply(nop, 1'b0, 0);
        chk("sat hold a_cnt", a_cnt, 4'hF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
